// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// FSM states and the datapath mode select of the iteration slice.
package hilo_pkg;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } mode_e;

endpackage

// File: rtl/muldiv_step.sv
// Combinational UNROLL-bit iteration slice: shift-add multiply or restoring
// divide on a 2*WIDTH accumulator {upper, lower}.
module muldiv_step
   import hilo_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  mode_e              mode,
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc_out
);

   logic [2*WIDTH-1:0] chain [0:UNROLL];

   assign chain[0] = acc_in;

   genvar gi;
   generate
      for (gi = 0; gi < UNROLL; gi++) begin : g_slice
         logic [WIDTH:0]     sum;
         logic [WIDTH:0]     shifted;
         logic [WIDTH:0]     diff;
         logic [2*WIDTH-1:0] nxt;

         // Multiply: lower half holds the remaining multiplier bits, upper half
         // the partial product. Divide: upper half is the partial remainder,
         // lower half shifts dividend bits out and quotient bits in.
         always_comb begin
            sum     = {1'b0, chain[gi][2*WIDTH-1:WIDTH]}
                      + (chain[gi][0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
            shifted = {chain[gi][2*WIDTH-1:WIDTH], chain[gi][WIDTH-1]};
            diff    = shifted - {1'b0, operand};
            if (mode == MODE_MUL) begin
               nxt = {sum, chain[gi][WIDTH-1:1]};
            end else if (!diff[WIDTH]) begin
               nxt = {diff[WIDTH-1:0], chain[gi][WIDTH-2:0], 1'b1};
            end else begin
               nxt = {shifted[WIDTH-1:0], chain[gi][WIDTH-2:0], 1'b0};
            end
         end

         assign chain[gi+1] = nxt;
      end
   endgenerate

   assign acc_out = chain[UNROLL];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine owning the HI/LO pair, with mthi/mtlo
// writes, pipeline stall request and flush of an in-flight operation.
module hilo_muldiv_unit
   import hilo_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Flush,
   input  logic             HiLoRead,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic             Stall,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int N  = WIDTH / UNROLL;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               is_div_q, is_div_d;
   logic               div_zero_q, div_zero_d;
   logic               neg_lo_q, neg_lo_d;
   logic               neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dz_pulse_q, dz_pulse_d;

   logic               op_mul, op_div, op_signed;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;

   logic [2*WIDTH-1:0] step_acc;
   mode_e              step_mode;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   always_comb begin
      op_mul    = (Op == OP_MULT) || (Op == OP_MULTU);
      op_div    = (Op == OP_DIV)  || (Op == OP_DIVU);
      op_signed = (Op == OP_MULT) || (Op == OP_DIV);
      a_neg     = op_signed & A[WIDTH-1];
      b_neg     = op_signed & B[WIDTH-1];
      a_mag     = a_neg ? -A : A;
      b_mag     = b_neg ? -B : B;
   end

   assign step_mode = is_div_q ? MODE_DIV : MODE_MUL;

   muldiv_step #(
      .WIDTH  (WIDTH),
      .UNROLL (UNROLL)
   ) u_step (
      .mode    (step_mode),
      .acc_in  (acc_q),
      .operand (opnd_q),
      .acc_out (step_acc)
   );

   // Sign correction; on divide-by-zero the dividend magnitude is still
   // untouched in the lower half, so re-signing it recovers the raw A.
   always_comb begin
      prod_fix = neg_lo_q ? -acc_q : acc_q;
      quo      = acc_q[WIDTH-1:0];
      rem      = acc_q[2*WIDTH-1:WIDTH];
      quo_fix  = neg_lo_q ? -quo : quo;
      rem_fix  = neg_hi_q ? -rem : rem;
      if (!is_div_q) begin
         {fix_hi, fix_lo} = prod_fix;
      end else if (div_zero_q) begin
         fix_hi = neg_hi_q ? -quo : quo;
         fix_lo = '1;
      end else begin
         fix_hi = rem_fix;
         fix_lo = quo_fix;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      div_zero_d = div_zero_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      dz_pulse_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (Start && !Flush) begin
               if (op_mul || op_div) begin
                  state_d    = ST_RUN;
                  cnt_d      = '0;
                  is_div_d   = op_div;
                  div_zero_d = op_div && (B == '0);
                  neg_lo_d   = a_neg ^ b_neg;
                  neg_hi_d   = a_neg;
                  acc_d      = {{WIDTH{1'b0}}, (op_mul ? b_mag : a_mag)};
                  opnd_d     = op_mul ? a_mag : b_mag;
               end else if (Op == OP_MTHI) begin
                  hi_d = A;
               end else if (Op == OP_MTLO) begin
                  lo_d = A;
               end
            end
         end

         ST_RUN: begin
            if (Flush) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (div_zero_q) begin
               state_d = ST_FIX;
               cnt_d   = '0;
            end else begin
               acc_d = step_acc;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_FIX;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end

         ST_FIX: begin
            // First FIX cycle commits HI/LO; the second shows Done while still busy.
            if (Flush || (cnt_q != '0)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               hi_d       = fix_hi;
               lo_d       = fix_lo;
               done_d     = 1'b1;
               dz_pulse_d = div_zero_q;
               cnt_d      = CW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         is_div_q   <= 1'b0;
         div_zero_q <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         dz_pulse_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         is_div_q   <= is_div_d;
         div_zero_q <= div_zero_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         dz_pulse_q <= dz_pulse_d;
      end
   end

   assign Busy    = (state_q != ST_IDLE);
   assign Done    = done_q;
   assign DivZero = dz_pulse_q;
   assign Stall   = Busy & (HiLoRead | Start);
   assign Hi      = hi_q;
   assign Lo      = lo_q;

endmodule
